// File: rtl/speed_ramp_controller_pkg.sv
// Shared definitions for the rover drive speed ramp: FSM encodings and default timing.
package speed_ramp_controller_pkg;

  localparam int DEF_SPEED_W         = 4;
  localparam int DEF_STEP_CYCLES     = 1000000;
  localparam int DEF_DEADTIME_CYCLES = 5000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_BRAKE = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

endpackage

// File: rtl/speed_ramp_controller_tick.sv
// Free-running period counter; pulses tick for one cycle at the terminal count.
module tick_gen
  import speed_ramp_controller_pkg::*;
#(
  parameter int PERIOD = DEF_STEP_CYCLES
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/speed_ramp_controller.sv
// Slews the PWM speed toward the switch target one step per tick, with
// brake / dead-time / flip sequencing on direction reversal.
module speed_ramp_controller
  import speed_ramp_controller_pkg::*;
#(
  parameter int SPEED_W         = DEF_SPEED_W,
  parameter int STEP_CYCLES     = DEF_STEP_CYCLES,
  parameter int DEADTIME_CYCLES = DEF_DEADTIME_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [SPEED_W-1:0] target_speed,
  input  logic               target_dir,
  output logic [SPEED_W-1:0] speed_out,
  output logic               dir_out,
  output logic               pwm_enable,
  output logic               at_target,
  output logic [1:0]         state_out
);

  localparam int DW = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME_CYCLES - 1);

  state_t             state, state_n;
  logic [SPEED_W-1:0] speed_n, eff_speed;
  logic               dir_n, pwm_n, at_target_n, dir_mis, tick;
  logic [DW-1:0]      dead_cnt, dead_n;

  tick_gen #(.PERIOD(STEP_CYCLES)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign eff_speed = run ? target_speed : '0;
  assign dir_mis   = (target_dir != dir_out);
  assign state_out = state;

  always_comb begin
    state_n = state;
    speed_n = speed_out;
    dir_n   = dir_out;
    pwm_n   = pwm_enable;
    dead_n  = dead_cnt;
    case (state)
      ST_IDLE: begin
        speed_n = '0;
        pwm_n   = 1'b0;
        if (eff_speed != '0) begin
          if (dir_mis) begin
            state_n = ST_DEAD;
            dead_n  = DEAD_LOAD;
          end else begin
            state_n = ST_RAMP;
            pwm_n   = 1'b1;
          end
        end
      end
      ST_RAMP: begin
        if (dir_mis && speed_out != '0) begin
          state_n = ST_BRAKE;
        end else if (speed_out == '0 && eff_speed == '0) begin
          state_n = ST_IDLE;
          pwm_n   = 1'b0;
        end else if (speed_out == '0 && dir_mis) begin
          state_n = ST_DEAD;
          pwm_n   = 1'b0;
          dead_n  = DEAD_LOAD;
        end else if (tick) begin
          if (speed_out < eff_speed) begin
            speed_n = speed_out + 1'b1;
          end else if (speed_out > eff_speed) begin
            speed_n = speed_out - 1'b1;
          end
        end
      end
      ST_BRAKE: begin
        if (!dir_mis) begin
          state_n = ST_RAMP;
        end else if (speed_out == '0) begin
          state_n = ST_DEAD;
          pwm_n   = 1'b0;
          dead_n  = DEAD_LOAD;
        end else if (tick) begin
          speed_n = speed_out - 1'b1;
          // PWM drops on the same edge the speed reaches zero
          if (speed_out == SPEED_W'(1)) begin
            state_n = ST_DEAD;
            pwm_n   = 1'b0;
            dead_n  = DEAD_LOAD;
          end
        end
      end
      ST_DEAD: begin
        speed_n = '0;
        pwm_n   = 1'b0;
        if (dead_cnt == '0) begin
          // Flip only if the reversal is still requested at expiry
          if (dir_mis) begin
            dir_n = ~dir_out;
          end
          if (eff_speed != '0) begin
            state_n = ST_RAMP;
            pwm_n   = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          dead_n = dead_cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign at_target_n = ((state == ST_IDLE) || (state == ST_RAMP)) &&
                       (speed_out == eff_speed) && !dir_mis;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      speed_out  <= '0;
      dir_out    <= 1'b0;
      pwm_enable <= 1'b0;
      at_target  <= 1'b0;
      dead_cnt   <= '0;
    end else begin
      state      <= state_n;
      speed_out  <= speed_n;
      dir_out    <= dir_n;
      pwm_enable <= pwm_n;
      at_target  <= at_target_n;
      dead_cnt   <= dead_n;
    end
  end

endmodule

// File: doc/speed_ramp_controller.md
Name: speed_ramp_controller

Overview:
Sits between the switch debouncer (switchesUp) and the PWM generator (speed/enable inputs) on the rover drive path. Slews the commanded 4-bit speed toward the switch target one step per ramp tick, which gives the motor soft start and soft stop. Handles direction reversal by ramping to zero, then holding a dead-time with the PWM disabled, then flipping direction and ramping up again.

Parameters:
SPEED_W, 4, width of the speed path; matches the PWM speed input.
STEP_CYCLES, 1000000, clock cycles per ramp step (10 ms at 100 MHz); minimum 2.
DEADTIME_CYCLES, 5000000, clock cycles with the PWM disabled before a direction flip; minimum 1.

Ports:
clock  input  1  100 MHz system clock
reset  input  1  asynchronous, active-high reset
run  input  1  drive request; when low, ramp down to 0
target_speed  input  SPEED_W  debounced speed request (switchesUp)
target_dir  input  1  requested direction (0 = forward, 1 = reverse)
speed_out  output  SPEED_W  ramped speed to the PWM speed input
dir_out  output  1  direction to the H-bridge
pwm_enable  output  1  to the PWM enable input
at_target  output  1  speed_out and dir_out match the effective target
state_out  output  2  current FSM state, for debug/LEDs

Behaviour:
- One clock domain. The async reset clears: speed_out=0, dir_out=0, pwm_enable=0, at_target=0, state=IDLE, tick counter=0, dead counter=0. All outputs are registered.
- Effective target: eff_speed = run ? target_speed : 0. Inputs are sampled every clock with no input synchronizer; debouncing happens upstream.
- Tick generator: a free-running counter that counts 0..STEP_CYCLES-1 and pulses tick for one cycle at the terminal count. It is reset only by reset and runs in every state.
- FSM encoding: IDLE=0, RAMP=1, BRAKE=2, DEAD=3.
- IDLE: speed_out=0, pwm_enable=0.
  - If eff_speed!=0 and target_dir!=dir_out, go to DEAD and load the dead counter.
  - Else if eff_speed!=0, go to RAMP and set pwm_enable=1 on the same transition edge.
- RAMP: on tick, speed_out moves by ±1 toward eff_speed.
  - If target_dir!=dir_out and speed_out!=0, go to BRAKE.
  - If speed_out==0 and eff_speed==0, go to IDLE with pwm_enable=0.
  - If speed_out==0 and target_dir!=dir_out, go to DEAD.
- BRAKE: on tick, speed_out decrements by 1. When it reaches 0, go to DEAD; pwm_enable drops in the same cycle speed_out becomes 0.
  - If target_dir returns to dir_out before zero is reached, go back to RAMP with no dead-time.
- DEAD: pwm_enable=0, speed_out=0. The counter runs DEADTIME_CYCLES cycles. At expiry, dir_out<=~dir_out.
  - Then go to RAMP if eff_speed!=0, else IDLE.
  - If target_dir changes back to dir_out during DEAD, finish the count anyway, then do not flip; apply the same RAMP/IDLE choice.
- Step size is exactly 1 per tick. No overshoot and no wrap: speed_out saturates at eff_speed and never goes below 0 or above 2^SPEED_W-1.
- If target_speed changes mid-ramp, the new value takes effect on the next tick. Reversing the slope takes effect immediately on the next tick.
- at_target=1 when state is RAMP or IDLE, speed_out==eff_speed, and dir_out==target_dir. It is registered, so it lags by 1 cycle.
- Reset asserted mid-ramp forces all outputs to their reset values immediately, because the reset is asynchronous. On release, the block restarts from IDLE with the tick counter at 0.
- Latency: the first speed_out increment occurs on the first tick after leaving IDLE, which is at most STEP_CYCLES cycles later.

Decomposition:
- Shared package/header holds: state encodings (ST_IDLE, ST_RAMP, ST_BRAKE, ST_DEAD), the default STEP_CYCLES and DEADTIME_CYCLES, and SPEED_W.
- One sub-module: tick_gen (parameter PERIOD; ports clock, reset, tick). It is reusable by the PWM and debouncer timing.
- The FSM, the saturating up/down speed register and the dead counter stay in the top module.

Test Plan (STEP_CYCLES=4, DEADTIME_CYCLES=8):
1. reset high at mid-operation, with speed_out=5 -> speed_out=0, pwm_enable=0, dir_out=0, state_out=0 within the same cycle. Hold reset high through this scenario.
2. After release, run=1, target_speed=3, target_dir=0 -> pwm_enable=1, speed_out goes 1,2,3 on three successive ticks (4 cycles apart), at_target=1 one cycle after reaching 3, and speed_out stays at 3.
3. At speed 3, target_dir=1 -> state BRAKE, speed_out 2,1,0 on ticks, pwm_enable=0 at 0, DEAD held exactly 8 cycles, dir_out=1, then speed_out ramps 1,2,3.
4. At speed 3 forward, set run=0 -> speed_out 2,1,0, then state IDLE, pwm_enable=0, dir_out unchanged at 0.
5. In BRAKE at speed 2, restore target_dir=0 -> return to RAMP, no DEAD entry, dir_out stays 0, speed_out climbs back to 3.
6. target_speed jumps 15->4 at speed_out=10 -> speed_out decrements one per tick to 4 with no undershoot. Then target_speed=15 ramps to 15 with no wrap past 15.
